dcm_prog_ctrl: RTL and testbench

Operator-facing programming stage placed directly upstream of the clock divider. It synchronizes and debounces three push-buttons (increment, decrement, apply) and keeps a staged 3-bit divider selection. On apply, it commits the staged value to `prog_out` and issues a one-cycle `update` strobe. `prog_out` and `update` drive the divider's `prog_in` and `update` inputs directly.

---
 rtl/dcm_prog_ctrl_if.sv | 27 ++
 rtl/dcm_prog_ctrl.sv | 90 +++++++++
 tb/tb_dcm_prog_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_prog_ctrl_if.sv
// rtl/dcm_prog_ctrl_if.sv - operator button and divider-programming signal bundle
// Signals:
//   btn_inc, btn_dec, btn_apply : raw active-high push-buttons, asynchronous to clk
//   prog_out                    : committed divider selection
//   update                      : one-cycle commit strobe, aligned with prog_out
//   prog_pending                : staged selection for display
//   dirty                       : staged selection differs from committed one
// master drives the buttons (operator side), slave is the controller.
interface dcm_prog_if;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_apply;
    logic [2:0] prog_out;
    logic       update;
    logic [2:0] prog_pending;
    logic       dirty;

    modport master (
        output btn_inc, btn_dec, btn_apply,
        input  prog_out, update, prog_pending, dirty
    );

    modport slave (
        input  btn_inc, btn_dec, btn_apply,
        output prog_out, update, prog_pending, dirty
    );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// rtl/dcm_prog_ctrl.sv - debounced push-button stage that stages and commits a 3-bit divider selection
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : dcm_prog_if.slave (raw buttons in; prog_out/update/prog_pending/dirty out)
// Parameters:
//   DEBOUNCE_CYCLES : cycles a synchronized level must hold before it is accepted (1..65535)
//   RESET_PROG      : reset value of staged and committed selections
module dcm_prog_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [2:0]  RESET_PROG      = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    dcm_prog_if.slave  bus
);
    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

    // Button index: 0 = inc, 1 = dec, 2 = apply
    logic [2:0]  raw;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  db;
    logic [2:0]  ev;
    logic [15:0] cnt [3];

    logic [2:0]  pend;
    logic [2:0]  committed;
    logic        upd_q;
    logic        dirty_q;
    logic [2:0]  pend_next;
    logic [2:0]  committed_next;

    assign raw = {bus.btn_apply, bus.btn_dec, bus.btn_inc};

    // Apply captures the staged value as it stood before any same-cycle inc/dec.
    always_comb begin
        pend_next      = pend;
        committed_next = committed;
        if (ev[0] && !ev[1] && pend != 3'd7) begin
            pend_next = pend + 3'd1;
        end else if (ev[1] && !ev[0] && pend != 3'd0) begin
            pend_next = pend - 3'd1;
        end
        if (ev[2]) begin
            committed_next = pend;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            ev        <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            pend      <= RESET_PROG;
            committed <= RESET_PROG;
            upd_q     <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            ev    <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LIMIT - 16'd1) begin
                    // Level held long enough: accept it; a rising acceptance is a press event.
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                    ev[i]  <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
            pend      <= pend_next;
            committed <= committed_next;
            upd_q     <= ev[2];
            dirty_q   <= (pend_next != committed_next);
        end
    end

    assign bus.prog_out     = committed;
    assign bus.update       = upd_q;
    assign bus.prog_pending = pend;
    assign bus.dirty        = dirty_q;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// tb/tb_dcm_prog_ctrl.sv - self-checking bench for dcm_prog_ctrl
module tb_dcm_prog_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcm_prog_if bus ();

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RESET_PROG     (3'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int upd_count = 0;

    // Reference model: history of raw samples per edge; a level is accepted once the
    // synchronized stream (raw delayed two edges) has disagreed for D consecutive edges.
    logic [2:0] hist[$];
    logic [2:0] acc;
    logic [2:0] evm;
    int         m_pend;
    int         m_out;
    int         m_upd;
    int         m_dirty;

    typedef struct {
        logic [2:0] btn;
        int         pend;
        int         out;
        int         dirty;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (D + 2) hist.push_back(3'b000);
        acc     = '0;
        evm     = '0;
        m_pend  = 0;
        m_out   = 0;
        m_upd   = 0;
        m_dirty = 0;
    endtask

    task automatic model_edge(input logic [2:0] r);
        int  np;
        int  n;
        bit  flip;
        if (!rst) begin
            model_reset();
        end else begin
            np = m_pend;
            if (evm[0] && !evm[1]) np = (m_pend < 7) ? m_pend + 1 : 7;
            else if (evm[1] && !evm[0]) np = (m_pend > 0) ? m_pend - 1 : 0;
            m_upd = evm[2] ? 1 : 0;
            if (evm[2]) m_out = m_pend;
            m_pend  = np;
            m_dirty = (m_pend != m_out) ? 1 : 0;
            hist.push_back(r);
            n   = hist.size();
            evm = '0;
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int k = n - 2 - D; k <= n - 3; k++) begin
                    if (hist[k][b] == acc[b]) flip = 1'b0;
                end
                if (flip) begin
                    acc[b] = ~acc[b];
                    evm[b] = acc[b];
                end
            end
            while (hist.size() > D + 3) void'(hist.pop_front());
        end
    endtask

    task automatic compare_all();
        chk("prog_out",     8'(bus.prog_out),     8'(m_out));
        chk("prog_pending", 8'(bus.prog_pending), 8'(m_pend));
        chk("update",       8'(bus.update),       8'(m_upd));
        chk("dirty",        8'(bus.dirty),        8'(m_dirty));
    endtask

    task automatic step(input logic [2:0] b);
        bus.btn_inc   = b[0];
        bus.btn_dec   = b[1];
        bus.btn_apply = b[2];
        @(posedge clk);
        model_edge(b);
        #1;
        if (bus.update === 1'b1) upd_count++;
        compare_all();
    endtask

    task automatic press(input logic [2:0] b);
        repeat (8) step(b);
        repeat (8) step(3'b000);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_apply = 1'b0;
        #1;
        compare_all();
        repeat (2) step(3'b000);
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] rb;
        int         up0;
        int         waited;

        tbl[0] = '{3'b001, 1, 0, 1};
        tbl[1] = '{3'b001, 2, 0, 1};
        tbl[2] = '{3'b100, 2, 2, 0};
        tbl[3] = '{3'b010, 1, 2, 1};
        tbl[4] = '{3'b011, 1, 2, 1};
        tbl[5] = '{3'b100, 1, 1, 0};
        tbl[6] = '{3'b100, 1, 1, 0};
        tbl[7] = '{3'b010, 0, 1, 1};
        tbl[8] = '{3'b010, 0, 1, 1};
        tbl[9] = '{3'b101, 1, 0, 1};

        bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_apply = 1'b0;
        model_reset();

        // Reset held while buttons toggle, then release with buttons low
        repeat (6) step(3'($urandom_range(0, 7)));
        step(3'b000);
        rst = 1'b1;
        up0 = upd_count;
        repeat (12) step(3'b000);
        chk("rst_prog_out", 8'(bus.prog_out), 8'd0);
        chk("rst_pending",  8'(bus.prog_pending), 8'd0);
        chk("rst_dirty",    8'(bus.dirty), 8'd0);
        chk("rst_no_update", 8'(upd_count - up0), 8'd0);

        // Glitch of 3 cycles is rejected; the following long press counts once
        up0 = upd_count;
        repeat (3) step(3'b001);
        step(3'b000);
        repeat (10) step(3'b001);
        repeat (10) step(3'b000);
        chk("db_pending", 8'(bus.prog_pending), 8'd1);
        chk("db_dirty",   8'(bus.dirty), 8'd1);
        chk("db_no_update", 8'(upd_count - up0), 8'd0);

        // Table of clean presses
        do_reset();
        for (int i = 0; i < 10; i++) begin
            press(tbl[i].btn);
            chk($sformatf("tbl%0d_pending", i), 8'(bus.prog_pending), 8'(tbl[i].pend));
            chk($sformatf("tbl%0d_out", i),     8'(bus.prog_out),     8'(tbl[i].out));
            chk($sformatf("tbl%0d_dirty", i),   8'(bus.dirty),        8'(tbl[i].dirty));
        end

        // Saturation
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            press(3'b001);
            chk("sat_inc", 8'(bus.prog_pending), 8'((i < 7) ? i : 7));
        end
        for (int i = 1; i <= 9; i++) begin
            press(3'b010);
            chk("sat_dec", 8'(bus.prog_pending), 8'((7 - i > 0) ? 7 - i : 0));
        end

        // Commit latency: pending=5, update exactly at the 7th edge (E6) after raw press
        do_reset();
        repeat (5) press(3'b001);
        for (int e = 0; e < 8; e++) begin
            step(3'b100);
            chk($sformatf("lat_update_e%0d", e), 8'(bus.update), 8'((e == 6) ? 1 : 0));
            if (e == 6) chk("lat_prog_out", 8'(bus.prog_out), 8'd5);
        end
        repeat (8) step(3'b000);
        chk("lat_dirty", 8'(bus.dirty), 8'd0);

        // Coinciding inc+apply, then inc+dec
        do_reset();
        repeat (2) press(3'b001);
        press(3'b101);
        chk("sim_out",     8'(bus.prog_out), 8'd2);
        chk("sim_pending", 8'(bus.prog_pending), 8'd3);
        chk("sim_dirty",   8'(bus.dirty), 8'd1);
        press(3'b011);
        chk("sim_incdec",  8'(bus.prog_pending), 8'd3);

        // Reset during the update cycle, apply held through release
        do_reset();
        press(3'b001);
        waited = 0;
        while (bus.update !== 1'b1 && waited < 20) begin
            step(3'b100);
            waited++;
        end
        chk("mid_upd_seen", 8'(bus.update), 8'd1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_upd_cut",  8'(bus.update), 8'd0);
        chk("mid_out_rst",  8'(bus.prog_out), 8'd0);
        chk("mid_pend_rst", 8'(bus.prog_pending), 8'd0);
        repeat (3) step(3'b100);
        rst = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step(3'b100);
            chk($sformatf("held_update_e%0d", e), 8'(bus.update), 8'((e == 6) ? 1 : 0));
        end
        chk("held_out", 8'(bus.prog_out), 8'd0);
        repeat (8) step(3'b000);

        // Reset mid-debounce
        press(3'b001);
        repeat (3) step(3'b001);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_db_pend", 8'(bus.prog_pending), 8'd0);
        chk("mid_db_dirty", 8'(bus.dirty), 8'd0);
        step(3'b000);
        rst = 1'b1;
        repeat (10) step(3'b000);
        chk("mid_db_quiet", 8'(bus.prog_pending), 8'd0);

        // Randomized sticky buttons against the model
        do_reset();
        rb = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            end
            step(rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
